// File: rtl/btb_ctrl.sv
// Branch target buffer control: combinational fetch-side prediction, one-stage
// execute-side read-modify-write update, and a post-reset sweep that zeroes storage.
module btb_ctrl #(
  parameter int unsigned NUM_SETS = 8,
  parameter logic [1:0]  INIT_CTR = 2'b10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  fetch_pc,
  output logic         pred_valid,
  output logic         pred_taken,
  output logic [31:0]  pred_target,
  input  logic         upd_valid,
  input  logic [31:0]  upd_pc,
  input  logic         upd_taken,
  input  logic [31:0]  upd_target,
  output logic [2:0]   read_index,
  input  logic [127:0] read_set,
  output logic [2:0]   update_index,
  input  logic [127:0] update_set,
  output logic [2:0]   write_index,
  output logic [127:0] write_set,
  output logic         write_en,
  output logic         init_done
);

  localparam int unsigned IDX_W = 3;
  localparam int unsigned TAG_W = 27;
  localparam int unsigned PC_W  = 30;
  localparam logic [IDX_W-1:0] LAST_SET = IDX_W'(NUM_SETS - 1);

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
    logic             rsv;
    logic             lru;
  } way_t;

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] init_cnt_q, init_cnt_d;
  logic             u_vld_q, u_vld_d;
  logic [PC_W-1:0]  u_pc_q, u_pc_d;
  logic             u_taken_q, u_taken_d;
  logic [31:0]      u_target_q, u_target_d;

  way_t   pw0, pw1, psel;
  logic   ph0, ph1;
  way_t   uw0, uw1, nw, nw0, nw1;
  logic   uh0, uh1, usel, upd_write;
  logic [127:0] new_set;
  logic   unused_bits;

  assign read_index   = fetch_pc[4:2];
  assign update_index = u_pc_q[IDX_W-1:0];

  // Fetch-side lookup; way0 wins when both ways hit
  always_comb begin
    pw0  = way_t'(read_set[63:0]);
    pw1  = way_t'(read_set[127:64]);
    ph0  = pw0.valid && (pw0.tag == fetch_pc[31:5]);
    ph1  = pw1.valid && (pw1.tag == fetch_pc[31:5]);
    psel = ph0 ? pw0 : pw1;
    pred_valid  = 1'b0;
    pred_taken  = 1'b0;
    pred_target = 32'd0;
    if (state_q == ST_RUN && (ph0 || ph1)) begin
      pred_valid  = 1'b1;
      pred_taken  = psel.ctr[1];
      pred_target = psel.target;
    end
  end

  assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], pw0.ctr[0], pw0.rsv, pw0.lru,
                         pw1.ctr[0], pw1.rsv, pw1.lru};

  // Update-side read-modify-write of the set selected by the captured PC
  always_comb begin
    uw0 = way_t'(update_set[63:0]);
    uw1 = way_t'(update_set[127:64]);
    uh0 = uw0.valid && (uw0.tag == u_pc_q[PC_W-1:IDX_W]);
    uh1 = uw1.valid && (uw1.tag == u_pc_q[PC_W-1:IDX_W]);
    if (uh0)             usel = 1'b0;
    else if (uh1)        usel = 1'b1;
    else if (!uw0.valid) usel = 1'b0;
    else if (!uw1.valid) usel = 1'b1;
    else                 usel = uw0.lru;
    nw        = usel ? uw1 : uw0;
    upd_write = 1'b0;
    if (uh0 || uh1) begin
      upd_write = 1'b1;
      if (u_taken_q) begin
        if (nw.ctr != 2'b11) nw.ctr = nw.ctr + 2'd1;
        nw.target = u_target_q;
      end else if (nw.ctr != 2'b00) begin
        nw.ctr = nw.ctr - 2'd1;
      end
    end else if (u_taken_q) begin
      upd_write = 1'b1;
      nw        = '0;
      nw.valid  = 1'b1;
      nw.tag    = u_pc_q[PC_W-1:IDX_W];
      nw.target = u_target_q;
      nw.ctr    = INIT_CTR;
    end
    nw.rsv  = 1'b0;
    nw.lru  = 1'b0;
    nw0     = usel ? uw0 : nw;
    nw1     = usel ? nw  : uw1;
    nw0.lru = ~usel;
    nw1.lru = 1'b0;
    new_set = {nw1, nw0};
  end

  // Init sweep / run control and storage write port
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    u_vld_d     = 1'b0;
    u_pc_d      = u_pc_q;
    u_taken_d   = u_taken_q;
    u_target_d  = u_target_q;
    write_en    = 1'b0;
    write_index = '0;
    write_set   = '0;
    init_done   = 1'b0;
    case (state_q)
      ST_INIT: begin
        write_en    = 1'b1;
        write_index = init_cnt_q;
        init_cnt_d  = init_cnt_q + IDX_W'(1);
        if (init_cnt_q == LAST_SET) state_d = ST_RUN;
      end
      ST_RUN: begin
        init_done = 1'b1;
        if (upd_valid) begin
          u_vld_d    = 1'b1;
          u_pc_d     = upd_pc[31:2];
          u_taken_d  = upd_taken;
          u_target_d = upd_target;
        end
        if (u_vld_q && upd_write) begin
          write_en    = 1'b1;
          write_index = update_index;
          write_set   = new_set;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
      u_vld_q    <= 1'b0;
      u_pc_q     <= '0;
      u_taken_q  <= 1'b0;
      u_target_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      u_vld_q    <= u_vld_d;
      u_pc_q     <= u_pc_d;
      u_taken_q  <= u_taken_d;
      u_target_q <= u_target_d;
    end
  end

endmodule

// File: tb/tb_btb_ctrl.sv
// Bench for btb_ctrl: behavioural 8x128 storage, init sweep check, table of
// update/fetch vectors with a write-port scoreboard, and reset-during-update sequence.
module tb_btb_ctrl;

  logic         clk;
  logic         rst_n;
  logic [31:0]  fetch_pc;
  logic         pred_valid, pred_taken;
  logic [31:0]  pred_target;
  logic         upd_valid, upd_taken;
  logic [31:0]  upd_pc, upd_target;
  logic [2:0]   read_index, update_index, write_index;
  logic [127:0] read_set, update_set, write_set;
  logic         write_en, init_done;

  logic [127:0] mem [8];
  logic [127:0] snap [8];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        do_upd;
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
    logic        exp_we;
    logic [31:0] fpc;
    logic        exp_pv;
    logic        exp_pt;
    logic [31:0] exp_ptgt;
  } vec_t;

  typedef struct packed {
    logic       we;
    logic [2:0] idx;
  } sb_t;

  vec_t vecs [15];
  sb_t  sbq [$];

  btb_ctrl #(.NUM_SETS(8), .INIT_CTR(2'b10)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .read_index(read_index), .read_set(read_set),
    .update_index(update_index), .update_set(update_set),
    .write_index(write_index), .write_set(write_set), .write_en(write_en),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (write_en) mem[write_index] <= write_set;
  assign read_set   = mem[read_index];
  assign update_set = mem[update_index];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic take_snap();
    for (int k = 0; k < 8; k++) snap[k] = mem[k];
  endtask

  function automatic logic mem_same();
    logic same = 1'b1;
    for (int k = 0; k < 8; k++) if (mem[k] !== snap[k]) same = 1'b0;
    return same;
  endfunction

  // Drive one resolved branch; write port is checked in the cycle after capture
  task automatic apply_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic exp_we);
    sb_t exp_e, got_e;
    @(negedge clk);
    upd_pc = pc; upd_taken = tk; upd_target = tgt; upd_valid = 1'b1;
    exp_e.we  = exp_we;
    exp_e.idx = exp_we ? pc[4:2] : 3'd0;
    sbq.push_back(exp_e);
    @(posedge clk);
    #1 upd_valid = 1'b0;
    got_e.we  = write_en;
    got_e.idx = write_index;
    if (sbq.size() == 0) check("sb_empty", 128'd1, 128'd0);
    else check("upd_write_port", 128'(got_e), 128'(sbq.pop_front()));
  endtask

  task automatic fetch_check(input string name, input logic [31:0] pc,
                             input logic pv, input logic pt, input logic [31:0] ptgt);
    @(posedge clk);
    #1 fetch_pc = pc;
    #1 check(name, {pred_valid, pred_taken, pred_target}, {pv, pt, ptgt});
  endtask

  task automatic init_sweep(input string name);
    for (int k = 0; k < 8; k++) begin
      check(name, {write_en, write_index, write_set == 128'd0, init_done, pred_valid},
            {1'b1, 3'(k), 1'b1, 1'b0, 1'b0});
      @(negedge clk);
    end
    check({name, "_done"}, {write_en, init_done, pred_valid}, {1'b0, 1'b1, 1'b0});
  endtask

  initial begin
    logic [127:0] exp_set1;
    logic         all_zero;
    vecs[0]  = '{1'b1, 32'h0000_1004, 1'b1, 32'h2000, 1'b1, 32'h1004, 1'b1, 1'b1, 32'h2000};
    vecs[1]  = '{1'b1, 32'h0000_1004, 1'b0, 32'h0,    1'b1, 32'h1004, 1'b1, 1'b0, 32'h2000};
    vecs[2]  = '{1'b1, 32'h0000_1004, 1'b0, 32'h0,    1'b1, 32'h1004, 1'b1, 1'b0, 32'h2000};
    vecs[3]  = '{1'b1, 32'h0000_1004, 1'b1, 32'h2100, 1'b1, 32'h1004, 1'b1, 1'b0, 32'h2100};
    vecs[4]  = '{1'b1, 32'h0000_1004, 1'b1, 32'h2100, 1'b1, 32'h1004, 1'b1, 1'b1, 32'h2100};
    vecs[5]  = '{1'b1, 32'h0000_1004, 1'b1, 32'h2100, 1'b1, 32'h1004, 1'b1, 1'b1, 32'h2100};
    vecs[6]  = '{1'b1, 32'h0000_1004, 1'b1, 32'h2100, 1'b1, 32'h1004, 1'b1, 1'b1, 32'h2100};
    vecs[7]  = '{1'b1, 32'h0000_1004, 1'b0, 32'h0,    1'b1, 32'h1004, 1'b1, 1'b1, 32'h2100};
    vecs[8]  = '{1'b1, 32'h0000_2004, 1'b1, 32'h3000, 1'b1, 32'h2004, 1'b1, 1'b1, 32'h3000};
    vecs[9]  = '{1'b1, 32'h0000_3004, 1'b1, 32'h4000, 1'b1, 32'h3004, 1'b1, 1'b1, 32'h4000};
    vecs[10] = '{1'b0, 32'h0,         1'b0, 32'h0,    1'b0, 32'h1004, 1'b0, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 32'h0,    1'b0, 32'h2006, 1'b1, 1'b1, 32'h3000};
    vecs[12] = '{1'b1, 32'h0000_5008, 1'b0, 32'h7777, 1'b0, 32'h5008, 1'b0, 1'b0, 32'h0};
    vecs[13] = '{1'b1, 32'h0000_001C, 1'b1, 32'h1234, 1'b1, 32'h001C, 1'b1, 1'b1, 32'h1234};
    vecs[14] = '{1'b0, 32'h0,         1'b0, 32'h0,    1'b0, 32'h003C, 1'b0, 1'b0, 32'h0};
    exp_set1 = {64'd0, 1'b1, 27'h80, 32'h2000, 2'b10, 1'b0, 1'b1};

    for (int k = 0; k < 8; k++) mem[k] = {$urandom, $urandom, $urandom, $urandom};
    rst_n = 1'b0; upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    fetch_pc = 32'h0000_1004;

    // In reset: sweep outputs parked at set 0, no prediction
    repeat (3) @(posedge clk);
    #1 check("reset_outputs", {write_en, write_index, write_set, init_done, pred_valid},
             {1'b1, 3'd0, 128'd0, 1'b0, 1'b0});
    @(negedge clk) rst_n = 1'b1;
    init_sweep("init_sweep");
    upd_valid = 1'b1;
    all_zero = 1'b1;
    for (int k = 0; k < 8; k++) if (mem[k] !== 128'd0) all_zero = 1'b0;
    check("storage_zeroed", 128'(all_zero), 128'd1);
    upd_valid = 1'b0;

    for (int i = 0; i < 15; i++) begin
      take_snap();
      if (vecs[i].do_upd) apply_upd(vecs[i].pc, vecs[i].taken, vecs[i].tgt, vecs[i].exp_we);
      fetch_check($sformatf("vec%0d_pred", i), vecs[i].fpc, vecs[i].exp_pv, vecs[i].exp_pt,
                  vecs[i].exp_ptgt);
      if (i == 0) check("alloc_set1", mem[1], exp_set1);
      if (vecs[i].do_upd && !vecs[i].exp_we) check("no_alloc_unchanged", 128'(mem_same()), 128'd1);
    end

    // Reset lands while a captured update is pending: the write must be dropped
    take_snap();
    @(negedge clk);
    upd_pc = 32'h0000_2004; upd_taken = 1'b1; upd_target = 32'h9999; upd_valid = 1'b1;
    @(posedge clk);
    #1 upd_valid = 1'b0;
    rst_n = 1'b0;
    #1 check("rst_drop_write", {write_en, write_index, write_set, init_done},
             {1'b1, 3'd0, 128'd0, 1'b0});
    @(posedge clk);
    #1 check("rst_set1_kept", mem[1], snap[1]);
    @(negedge clk) rst_n = 1'b1;
    init_sweep("reinit_sweep");
    fetch_check("post_rst_2004", 32'h0000_2004, 1'b0, 1'b0, 32'h0);
    fetch_check("post_rst_3004", 32'h0000_3004, 1'b0, 1'b0, 32'h0);
    fetch_check("post_rst_001c", 32'h0000_001C, 1'b0, 1'b0, 32'h0);
    check("sb_drained", 128'(sbq.size()), 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/btb_ctrl.md
Name: btb_ctrl

Overview:
- Control stage wrapped around the 8-set x 128-bit BTB storage file; drives its read/update/write ports and consumes its read_set/update_set.
- Fetch side: combinational tag compare on the fetch PC produces the prediction.
- Execute side: registered read-modify-write update path maintains per-way 2-bit counters and per-set LRU.
- After reset, an init FSM sweeps all 8 sets to zero so the storage needs no initial block.

Parameters:
- NUM_SETS, 8, number of sets; fixed to match 3-bit storage index.
- INIT_CTR, 2'b10, counter value written on allocation (weakly taken).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- fetch_pc  in  32  fetch-stage PC
- pred_valid  out  1  fetch_pc hit in BTB
- pred_taken  out  1  hit and counter[1]==1
- pred_target  out  32  target of hitting way (0 on miss)
- upd_valid  in  1  resolved branch from execute
- upd_pc  in  32  PC of resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  32  actual target
- read_index  out  3  to storage, = fetch_pc[4:2]
- read_set  in  128  from storage
- update_index  out  3  to storage, registered upd index
- update_set  in  128  from storage
- write_index  out  3  to storage
- write_set  out  128  to storage
- write_en  out  1  to storage
- init_done  out  1  init sweep complete

Behaviour:
- Reset is asynchronous and active-low (rst_n). Clock is clk. One clock domain.
- Set layout: way1 = [127:64], way0 = [63:0].
  - Per way: valid [63], tag [62:36] = pc[31:5], target [35:4], ctr [3:2], [1] reserved 0.
  - Bit [0] of way0 is set LRU: the way to replace next. Bit [0] of way1 is reserved 0.
- Index = pc[4:2]; pc[1:0] ignored.
- FSM states INIT, RUN. Reset state: INIT, init_cnt=0.
- INIT:
  - write_en=1, write_index=init_cnt, write_set=0.
  - init_cnt increments each cycle.
  - After the write of set 7, go to RUN.
  - INIT is entered only by reset; rst_n low mid-RUN returns to INIT, cnt 0, and drops the pending update.
- Output values while in reset/INIT: write_en=1, write_index=init_cnt (0 in reset), write_set=0, init_done=0, pred_valid=0, pred_taken=0, pred_target=0. upd_valid is ignored (not captured).
- RUN:
  - init_done=1.
  - Prediction is combinational from read_set.
  - hit_w = valid && tag == fetch_pc[31:5].
  - If both ways hit, way0 wins.
  - Lookup never writes and never changes LRU.
- Update pipeline, 1 register stage:
  - At clock edge E, with upd_valid=1 in RUN, capture pc/taken/target into u_* and set u_vld.
  - During the following cycle: update_index=u_pc[4:2]; new set computed combinationally from update_set; write_en=u_vld; write_index=update_index. Storage commits at edge E+1.
  - Back-to-back updates to the same set need no forwarding: the second reads update_set after the first's commit.
- Update rules, applied to the selected way only; other way unchanged:
  - Hit: ctr saturating +1 if taken, -1 if not (min 0, max 3). If taken, target=u_target. LRU=other way.
  - Miss, taken: victim = first invalid way (way0 before way1); else the way named by LRU. Victim gets valid=1, tag, target, ctr=INIT_CTR. LRU=other way.
  - Miss, not taken: write_en=0 (no allocation).
- When u_vld=0, write_en=0, write_index=0, write_set=0.

Test Plan:
- Reset then release -> write_en=1 for exactly 8 cycles, write_index 0..7, write_set=0; init_done rises the next cycle; pred_valid=0 throughout.
- Update pc=0x0000_1004 taken target=0x2000, then fetch_pc=0x1004 -> write_en one cycle after capture, index 1, way0 valid, ctr=2; pred_valid=1, pred_taken=1, pred_target=0x2000.
- Same pc updated not-taken twice -> ctr 2->1->0, pred_taken=0; then 4 taken -> ctr saturates at 3, never wraps to 0.
- Three taken branches with the same index 1 (pc 0x1004, 0x2004, 0x3004) -> way0, way1, then way0 (LRU) evicted; 0x1004 now misses, 0x2004 and 0x3004 hit.
- Miss with upd_taken=0 -> write_en stays 0, storage unchanged.
- rst_n low one cycle after upd_valid capture -> no update write; INIT sweep restarts at index 0; prior entries read as misses afterwards.
